seg_scan: RTL and testbench
===========================

SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 The block SHALL have parameter DIV, default 50000, giving clocks per digit slot (1 ms at 50 MHz); legal range 2..2^20.
REQ-002 The block SHALL have parameter GUARD, default 4, giving blanking clocks at the start of each digit slot; legal range 0..DIV-1.
REQ-003 CLK  input  1  single system clock; all state changes on its rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 DATA  input  16  four 4-bit digit codes; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-006 LOAD  input  1  capture-request strobe for DATA, sampled on every clock.
REQ-007 LZB  input  1  leading-zero blanking enable, level-sensitive.
REQ-008 NIB  output  4  digit code fed to the downstream 7-segment decoder input.
REQ-009 AN  output  4  digit enables, active-low, one-hot-low; bit k selects digit k.
REQ-010 FRAME  output  1  one-clock pulse marking the start of each scan frame.

Function
REQ-011 The block SHALL keep a slot counter CNT (width ceil(log2 DIV)) that counts 0..DIV-1 and wraps to 0.
REQ-012 The block SHALL keep a digit index IDX (2 bits) that increments modulo 4 on the clock where CNT wraps (3->0 wraps).
REQ-013 A frame boundary SHALL be the clock edge where CNT wraps while IDX=3.
REQ-014 FRAME SHALL be 1 for exactly the one cycle in which IDX=0 and CNT=0 after a frame boundary, else 0.
REQ-015 The block SHALL hold a 16-bit pending register PEND and a pending flag PV; LOAD=1 SHALL write DATA into PEND and set PV.
REQ-016 Multiple LOADs before a frame boundary SHALL leave only the last DATA in PEND.
REQ-017 At a frame boundary with PV=1, display register DISP SHALL take PEND and PV SHALL clear.
REQ-018 At a frame boundary with LOAD=1 in the same cycle, DISP SHALL take DATA directly and PV SHALL clear.
REQ-019 DISP SHALL NOT change at any clock other than a frame boundary; the displayed value never tears mid-frame.
REQ-020 While CNT<GUARD, the slot SHALL be blanked: AN=4'b1111 and NIB=4'hF.
REQ-021 Otherwise AN SHALL drive bit IDX low and all other bits high, and NIB SHALL equal DISP[4*IDX+3:4*IDX].
REQ-022 With LZB=1, digit k (k=3,2,1) SHALL be suppressed when DISP nibbles k..3 are all 4'h0; suppressed slots drive AN=4'b1111, NIB=4'hF.
REQ-023 Digit 0 SHALL never be suppressed by LZB.
REQ-024 Nibbles 4'hA..4'hF SHALL pass through to NIB unchanged; the decoder blanks them.
REQ-025 AN, NIB and FRAME SHALL be driven directly from flip-flops, with no combinational path from any input.
REQ-026 Output values SHALL correspond to the CNT/IDX/DISP state of the same cycle, so registered outputs are computed from next-state.

Reset
REQ-027 While RST=0, the block SHALL force, independent of CLK: CNT=0, IDX=0, DISP=16'h0000, PEND=16'h0000, PV=0, AN=4'b1111, NIB=4'hF, FRAME=0.
REQ-028 The first rising edge after RST deasserts SHALL start slot 0 of frame 0 with CNT=0.
REQ-029 FRAME SHALL NOT pulse for this first frame.
REQ-030 Reset asserted mid-operation SHALL discard pending LOAD data.

Verification (DIV=8, GUARD=2)
REQ-031 Reset release, DATA idle: cycles 0-1 AN=1111/NIB=F, cycles 2-7 AN=1110/NIB=0, then digit 1 slot AN=1101; AN pattern repeats every 32 cycles.
REQ-032 LOAD=1 with DATA=16'h1234 at cycle 5: digits show 0 until the next frame boundary, then slots show NIB 4,3,2,1 with AN 1110,1101,1011,0111, and FRAME pulses at that frame start.
REQ-033 LZB=1, DISP=16'h0050: digit 3 and digit 2 slots AN=1111/NIB=F; digit 1 shows NIB=5; digit 0 shows NIB=0.
REQ-034 LZB=1, DISP=16'h0000: only the digit 0 slot is active (AN=1110, NIB=0).
REQ-035 LZB=1, DISP=16'h0000 with LZB toggled to 0 mid-frame: all four digits show 0 from the next non-guard slot.
REQ-036 LOAD with DATA=16'h9876 on a frame-boundary cycle, plus an earlier LOAD of 16'h1111 in the same frame: the new frame shows 6,7,8,9; 1111 is never displayed.
REQ-037 RST=0 asserted asynchronously mid-slot at IDX=2: AN=1111, NIB=F, FRAME=0 before the next CLK edge; after release, scanning restarts at digit 0 with DISP=0.

Source files
------------

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - four-digit multiplexed display scanner with frame-synchronous update and leading-zero blanking
module seg_scan #(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned GUARD = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] DATA,
  input  logic        LOAD,
  input  logic        LZB,
  output logic [3:0]  NIB,
  output logic [3:0]  AN,
  output logic        FRAME
);

  localparam int unsigned CW      = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          run_q, run_d;
  logic [15:0]   disp_q, disp_d;
  logic [15:0]   pend_q, pend_d;
  logic          pv_q, pv_d;
  logic [3:0]    an_q, an_d;
  logic [3:0]    nib_q, nib_d;
  logic          frame_q, frame_d;

  logic          wrap;
  logic          boundary;
  logic [3:0]    digit;
  logic          suppress;
  logic          blank;

  // Slot/digit sequencing and the pending-to-display handoff at frame boundaries.
  // The first edge after reset only arms the scanner so that the first observed
  // cycle is slot 0 with CNT=0.
  always_comb begin
    run_d    = 1'b1;
    wrap     = run_q && (cnt_q == CNT_MAX);
    boundary = wrap && (idx_q == 2'd3);
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    pv_d     = pv_q;
    if (run_q) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
    if (wrap) begin
      idx_d = idx_q + 2'd1;
    end
    if (LOAD) begin
      pend_d = DATA;
      pv_d   = 1'b1;
    end
    if (boundary) begin
      if (LOAD) begin
        disp_d = DATA;
      end else if (pv_q) begin
        disp_d = pend_q;
      end
      pv_d = 1'b0;
    end
  end

  // Output values are derived from next state so the registered outputs line up
  // with the CNT/IDX/DISP of the cycle they are visible in.
  always_comb begin
    digit    = 4'h0;
    suppress = 1'b0;
    case (idx_d)
      2'd0: begin
        digit    = disp_d[3:0];
        suppress = 1'b0;
      end
      2'd1: begin
        digit    = disp_d[7:4];
        suppress = LZB && (disp_d[15:4] == 12'h000);
      end
      2'd2: begin
        digit    = disp_d[11:8];
        suppress = LZB && (disp_d[15:8] == 8'h00);
      end
      default: begin
        digit    = disp_d[15:12];
        suppress = LZB && (disp_d[15:12] == 4'h0);
      end
    endcase
    blank   = (cnt_d < GUARD_C) || suppress;
    an_d    = blank ? 4'b1111 : ~(4'b0001 << idx_d);
    nib_d   = blank ? 4'hF : digit;
    frame_d = boundary;
  end

  // State and output registers; reset forces a blanked, idle display.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      run_q   <= 1'b0;
      disp_q  <= 16'h0000;
      pend_q  <= 16'h0000;
      pv_q    <= 1'b0;
      an_q    <= 4'b1111;
      nib_q   <= 4'hF;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      run_q   <= run_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      pv_q    <= pv_d;
      an_q    <= an_d;
      nib_q   <= nib_d;
      frame_q <= frame_d;
    end
  end

  assign AN    = an_q;
  assign NIB   = nib_q;
  assign FRAME = frame_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - randomized scoreboard bench for seg_scan against a cycle-arithmetic reference model
module tb_seg_scan;

  localparam int DIV   = 8;
  localparam int GUARD = 2;
  localparam int FLEN  = 4 * DIV;

  logic        CLK;
  logic        RST;
  logic [15:0] DATA;
  logic        LOAD;
  logic        LZB;
  logic [3:0]  NIB;
  logic [3:0]  AN;
  logic        FRAME;

  typedef struct {
    int         t;
    logic [3:0] an;
    logic [3:0] nib;
    logic       fr;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  seg_scan #(.DIV(DIV), .GUARD(GUARD)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .DATA  (DATA),
    .LOAD  (LOAD),
    .LZB   (LZB),
    .NIB   (NIB),
    .AN    (AN),
    .FRAME (FRAME)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] req, input int t);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0d actual=%h required=%h", name, t, act, req);
    end
  endtask

  // Reference model: the display is a sequence of frames of 4*DIV cycles; cycle t
  // belongs to digit (t/DIV)%4 at position t%DIV. DISP changes only when t is a
  // nonzero multiple of the frame length.
  initial begin : model
    int         t;
    bit         started;
    bit         bnd;
    int         idx;
    int         pos;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    logic [15:0] upper;
    bit         m_pv;
    bit         sup;
    exp_t       e;
    started = 0;
    t       = 0;
    m_disp  = 16'h0;
    m_pend  = 16'h0;
    m_pv    = 0;
    forever begin
      @(posedge CLK);
      if (!RST) begin
        started = 0;
        m_disp  = 16'h0;
        m_pend  = 16'h0;
        m_pv    = 0;
      end else begin
        t       = started ? t + 1 : 0;
        started = 1;
        bnd     = (t > 0) && (t % FLEN == 0);
        if (bnd) begin
          if (LOAD) m_disp = DATA;
          else if (m_pv) m_disp = m_pend;
          m_pv = 0;
          if (LOAD) m_pend = DATA;
        end else if (LOAD) begin
          m_pend = DATA;
          m_pv   = 1;
        end
        pos   = t % DIV;
        idx   = (t / DIV) % 4;
        upper = m_disp >> (4 * idx);
        sup   = LZB && (idx != 0) && (upper == 16'h0);
        e.t   = t;
        e.fr  = bnd;
        if (pos < GUARD || sup) begin
          e.an  = 4'b1111;
          e.nib = 4'hF;
        end else begin
          e.an  = ~(4'b0001 << idx);
          e.nib = upper[3:0];
        end
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: every out-of-reset clock the DUT presents one output word; compare it
  // with the oldest expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check4("an", AN, e.an, e.t);
        check4("nib", NIB, e.nib, e.t);
        check4("frame", {3'b000, FRAME}, {3'b000, e.fr}, e.t);
      end
    end
  end

  function automatic logic [15:0] rand_data();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 5))
      0: rand_data = 16'h0000;
      1: rand_data = r & 16'h000F;
      2: rand_data = r & 16'h00FF;
      3: rand_data = r & 16'h0FFF;
      default: rand_data = r;
    endcase
  endfunction

  // Inputs applied on the falling edge feed the rising edge that produces cycle t=cyc.
  task automatic cycle_in(input logic ld, input logic [15:0] d, input logic lz);
    @(negedge CLK);
    LOAD = ld;
    DATA = d;
    LZB  = lz;
    cyc++;
  endtask

  task automatic release_reset();
    @(negedge CLK);
    RST  = 1'b1;
    LOAD = 1'b0;
    DATA = 16'h0;
    LZB  = 1'b0;
    cyc  = 1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check4({tag, "_an"}, AN, 4'b1111, -1);
    check4({tag, "_nib"}, NIB, 4'hF, -1);
    check4({tag, "_frame"}, {3'b000, FRAME}, 4'h0, -1);
  endtask

  initial begin : stim
    logic lz;
    RST  = 1'b0;
    LOAD = 1'b0;
    DATA = 16'h0;
    LZB  = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("reset");

    release_reset();
    // Idle scan, then a single 1234 load early in a frame.
    repeat (40) cycle_in(1'b0, 16'h0, 1'b0);
    cycle_in(1'b1, 16'h1234, 1'b0);
    repeat (70) cycle_in(1'b0, 16'h0, 1'b0);

    // Leading-zero blanking on specific values, then toggled off mid-frame.
    while (cyc % FLEN != 3) cycle_in(1'b0, 16'h0, 1'b1);
    cycle_in(1'b1, 16'h0050, 1'b1);
    repeat (70) cycle_in(1'b0, 16'h0, 1'b1);
    while (cyc % FLEN != 3) cycle_in(1'b0, 16'h0, 1'b1);
    cycle_in(1'b1, 16'h0000, 1'b1);
    repeat (FLEN + FLEN / 2) cycle_in(1'b0, 16'h0, 1'b1);
    repeat (FLEN) cycle_in(1'b0, 16'h0, 1'b0);

    // Earlier load superseded by a load on the boundary cycle itself.
    repeat (6) begin
      while (cyc % FLEN != 10) cycle_in(1'b0, 16'h0, 1'b0);
      cycle_in(1'b1, 16'h1111, 1'b0);
      while (cyc % FLEN != 0) cycle_in(1'b0, 16'h0, 1'b0);
      cycle_in(1'b1, ($urandom_range(0, 1) == 0) ? 16'h9876 : rand_data(), 1'b0);
    end

    // Randomized loads, data shapes and blanking enable.
    lz = 1'b0;
    repeat (1500) begin
      if ($urandom_range(0, 39) == 0) lz = ~lz;
      cycle_in($urandom_range(0, 11) == 0, rand_data(), lz);
    end

    // Asynchronous reset mid-slot in digit 2, with a load still pending.
    while (!(((cyc / DIV) % 4 == 2) && (cyc % DIV == 4))) cycle_in($urandom_range(0, 3) == 0, rand_data(), 1'b0);
    cycle_in(1'b1, 16'hABCD, 1'b0);
    @(posedge CLK);
    #3;
    RST = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("reset_hold");
    release_reset();
    repeat (3 * FLEN) cycle_in(1'b0, 16'h0, 1'b0);

    @(posedge CLK);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
